// File: rtl/ioport_pkg.sv
// ioport_pkg: shared types and helpers for the ioport_bank I/O-port controller.
//   state_e     bus-cycle FSM states
//   MAX_PORTS   largest supported number of port pairs
//   WAIT_W      width of the wait-state down-counter
//   is_out / is_in / is_status  word-offset decoders for a given port count
package ioport_pkg;

    localparam int unsigned MAX_PORTS = 8;
    localparam int unsigned WAIT_W    = 4;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StAck
    } state_e;

    // Port count as seen by the decoder; never decodes beyond the largest legal window.
    function automatic int unsigned window_ports(input int unsigned num_ports);
        return (num_ports > MAX_PORTS) ? MAX_PORTS : num_ports;
    endfunction

    function automatic logic is_out(input logic [7:0] offset, input int unsigned num_ports);
        return (offset[0] == 1'b0) && (32'(offset) < 2 * window_ports(num_ports));
    endfunction

    function automatic logic is_in(input logic [7:0] offset, input int unsigned num_ports);
        return (offset[0] == 1'b1) && (32'(offset) < 2 * window_ports(num_ports));
    endfunction

    function automatic logic is_status(input logic [7:0] offset, input int unsigned num_ports);
        return 32'(offset) == 2 * window_ports(num_ports);
    endfunction

endpackage

// File: rtl/ioport_sync.sv
// ioport_sync: 16-bit two-flop input synchroniser with change detection.
//   clk, reset_n  clock and asynchronous active-low reset (all flops reset to 0)
//   async_in      asynchronous external input
//   sync_out      synchronised value
//   changed       high while the synchronised value differs from its previous value
module ioport_sync (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] async_in,
    output logic [15:0] sync_out,
    output logic        changed
);

    logic [15:0] meta_q;
    logic [15:0] sync_q;
    logic [15:0] prev_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta_q <= '0;
            sync_q <= '0;
            prev_q <= '0;
        end else begin
            meta_q <= async_in;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign sync_out = sync_q;
    assign changed  = (sync_q != prev_q);

endmodule

// File: rtl/ioport_bank.sv
// ioport_bank: 68000 glue-bus I/O-port controller.
//   clk, reset_n     bus clock, asynchronous active-low reset
//   enable           I/O-window select from the glue decoder
//   d                bidirectional data bus (driven on reads while enable is high)
//   addr             word offset within the window
//   uds, lds, write  active-low byte strobes, write/read select
//   dtack, berr      active-low cycle termination, tri-stated while enable is low
//   irq              active-low level interrupt, asserted while any change flag is set
//   port_out         output latches, port i at [16i+15:16i]
//   port_in          asynchronous external inputs, port i at [16i+15:16i]
module ioport_bank
    import ioport_pkg::*;
#(
    parameter int unsigned NUM_PORTS   = 4,
    parameter int unsigned WAIT_STATES = 1,
    parameter logic [15:0] OUT_RESET   = 16'h0000
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   enable,
    inout  wire  [15:0]            d,
    input  logic [7:0]             addr,
    input  logic                   lds,
    input  logic                   uds,
    input  logic                   write,
    output wire                    dtack,
    output wire                    berr,
    output logic                   irq,
    output logic [16*NUM_PORTS-1:0] port_out,
    input  logic [16*NUM_PORTS-1:0] port_in
);

    localparam logic [WAIT_W-1:0] WaitLoad = WAIT_W'(WAIT_STATES);
    localparam bit                ZeroWait = (WAIT_STATES == 0);

    state_e            state_q;
    logic [WAIT_W-1:0] count_q;
    logic [15:0]       rdata_q;
    logic [15:0]       rdata_mux;

    logic [15:0]          out_q    [NUM_PORTS];
    logic [15:0]          out_d    [NUM_PORTS];
    logic [15:0]          sync_val [NUM_PORTS];
    logic [NUM_PORTS-1:0] flags_q;
    logic [NUM_PORTS-1:0] flags_d;
    logic [NUM_PORTS-1:0] chg;
    logic [NUM_PORTS-1:0] clr;

    logic        mapped;
    logic        enter_ack;
    logic        do_write;
    logic [15:0] lane_mask;
    logic [15:0] wdata_m;

    for (genvar g = 0; g < NUM_PORTS; g++) begin : g_port
        assign port_out[16*g +: 16] = out_q[g];

        ioport_sync u_sync (
            .clk      (clk),
            .reset_n  (reset_n),
            .async_in (port_in[16*g +: 16]),
            .sync_out (sync_val[g]),
            .changed  (chg[g])
        );
    end

    assign mapped = is_out(addr, NUM_PORTS) | is_in(addr, NUM_PORTS) | is_status(addr, NUM_PORTS);

    // The edge that moves the FSM into ACK is the single commit point of a cycle.
    assign enter_ack = enable && (((state_q == StIdle) && ZeroWait) ||
                                  ((state_q == StWait) && (count_q == '0)));
    assign do_write  = enter_ack && write;
    assign lane_mask = {{8{~uds}}, {8{~lds}}};
    assign wdata_m   = d & lane_mask;

    always_comb begin
        rdata_mux = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (addr == 8'(2 * i))     rdata_mux = out_q[i];
            if (addr == 8'(2 * i + 1)) rdata_mux = sync_val[i];
        end
        if (is_status(addr, NUM_PORTS)) rdata_mux = 16'(flags_q);
    end

    always_comb begin
        for (int i = 0; i < NUM_PORTS; i++) begin
            out_d[i] = out_q[i];
            if (do_write && (addr == 8'(2 * i))) begin
                out_d[i] = (out_q[i] & ~lane_mask) | wdata_m;
            end
        end
    end

    // A change detected on the clearing edge wins over the W1C.
    always_comb begin
        clr     = (do_write && is_status(addr, NUM_PORTS)) ? wdata_m[NUM_PORTS-1:0] : '0;
        flags_d = (flags_q & ~clr) | chg;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            count_q <= '0;
            rdata_q <= '0;
        end else if (!enable) begin
            state_q <= StIdle;
            count_q <= '0;
            rdata_q <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (ZeroWait) begin
                        state_q <= StAck;
                        rdata_q <= mapped ? rdata_mux : 16'h0000;
                    end else begin
                        state_q <= StWait;
                        count_q <= WaitLoad - 1'b1;
                    end
                end
                StWait: begin
                    if (count_q == '0) begin
                        state_q <= StAck;
                        rdata_q <= mapped ? rdata_mux : 16'h0000;
                    end else begin
                        count_q <= count_q - 1'b1;
                    end
                end
                StAck: begin
                    state_q <= StAck;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_PORTS; i++) out_q[i] <= OUT_RESET;
            flags_q <= '0;
        end else begin
            for (int i = 0; i < NUM_PORTS; i++) out_q[i] <= out_d[i];
            flags_q <= flags_d;
        end
    end

    assign irq   = ~|flags_q;
    assign dtack = enable ? ~((state_q == StAck) & mapped)  : 1'bz;
    assign berr  = enable ? ~((state_q == StAck) & ~mapped) : 1'bz;
    assign d     = (enable && !write) ? rdata_q : 16'bz;

endmodule

// File: tb/tb_ioport_bank.sv
// Bench for ioport_bank: directed checks plus randomized bus traffic against a reference model.
// u_dut uses NUM_PORTS=4, WAIT_STATES=1; u_dut3 uses WAIT_STATES=3 and a non-zero OUT_RESET.
module tb_ioport_bank;

    localparam int unsigned NP = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        enable = 1'b0;
    logic        enable3 = 1'b0;
    logic        write = 1'b0;
    logic        uds = 1'b1;
    logic        lds = 1'b1;
    logic [7:0]  addr = '0;
    logic [63:0] port_in = '0;
    logic [15:0] d_drv = '0;
    logic [15:0] d3_drv = '0;
    logic        d_oe = 1'b0;

    wire  [15:0] d;
    wire  [15:0] d3;
    wire         dtack;
    wire         berr;
    wire         dtack3;
    wire         berr3;
    logic        irq;
    logic        irq3;
    logic [63:0] port_out;
    logic [63:0] port_out3;

    // Weak pull-downs: a released (tri-stated) line reads 0, a driven-high line reads 1.
    pulldown (dtack);
    pulldown (berr);
    pulldown (dtack3);
    pulldown (berr3);

    assign d  = d_oe ? d_drv : 16'bz;
    assign d3 = write ? d3_drv : 16'bz;

    always #5 clk = ~clk;

    ioport_bank #(
        .NUM_PORTS   (NP),
        .WAIT_STATES (1),
        .OUT_RESET   (16'h0000)
    ) u_dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .enable   (enable),
        .d        (d),
        .addr     (addr),
        .lds      (lds),
        .uds      (uds),
        .write    (write),
        .dtack    (dtack),
        .berr     (berr),
        .irq      (irq),
        .port_out (port_out),
        .port_in  (port_in)
    );

    ioport_bank #(
        .NUM_PORTS   (NP),
        .WAIT_STATES (3),
        .OUT_RESET   (16'h5A00)
    ) u_dut3 (
        .clk      (clk),
        .reset_n  (reset_n),
        .enable   (enable3),
        .d        (d3),
        .addr     (addr),
        .lds      (lds),
        .uds      (uds),
        .write    (write),
        .dtack    (dtack3),
        .berr     (berr3),
        .irq      (irq3),
        .port_out (port_out3),
        .port_in  (port_in)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // One bus cycle on u_dut; lat is the edge index (edge 0 samples enable) of termination.
    task automatic bus(input logic wr, input logic [7:0] a, input logic [15:0] wd,
                       input logic u, input logic l, output logic [15:0] rd,
                       output logic ack, output logic err, output int lat,
                       output logic [15:0] early);
        @(negedge clk);
        addr = a; write = wr; uds = u; lds = l; d_drv = wd; d_oe = wr; enable = 1'b1;
        lat = -1; ack = 1'b0; err = 1'b0; early = 16'hxxxx;
        for (int e = 0; e < 20; e++) begin
            @(posedge clk);
            #1;
            if (e == 0) early = d;
            if (dtack === 1'b0 || berr === 1'b0) begin
                lat = e;
                ack = (dtack === 1'b0);
                err = (berr === 1'b0);
                break;
            end
        end
        rd = d;
        @(negedge clk);
        enable = 1'b0; d_oe = 1'b0; write = 1'b0;
    endtask

    task automatic wait_ack3(output int lat);
        lat = -1;
        for (int e = 0; e < 20; e++) begin
            @(posedge clk);
            #1;
            if (dtack3 === 1'b0) begin
                lat = e;
                break;
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] rd, early, wd, mask, v, exp_rd;
        logic        ack, err, wr, su, sl, exp_map;
        logic [7:0]  a;
        int          lat, p, idx;
        logic [15:0] out_m [NP];
        logic [15:0] in_m  [NP];
        logic [NP-1:0] flags_m;
        logic [63:0] exp_po;

        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("rst_port_out", port_out, 64'h0);
        check("rst_port_out3", port_out3, {4{16'h5A00}});
        check("rst_irq", irq, 1'b1);
        check("rst_dtack_released", dtack, 1'b0);
        check("rst_berr_released", berr, 1'b0);

        bus(1'b1, 8'd2, 16'hA55A, 1'b0, 1'b0, rd, ack, err, lat, early);
        check("wr2_ack", ack, 1'b1);
        check("wr2_lat", lat, 1);
        check("wr2_latch", port_out[31:16], 16'hA55A);

        bus(1'b0, 8'd2, 16'h0, 1'b0, 1'b0, rd, ack, err, lat, early);
        check("rd2_early_zero", early, 16'h0000);
        check("rd2_data", rd, 16'hA55A);

        bus(1'b1, 8'd0, 16'hFFFF, 1'b1, 1'b0, rd, ack, err, lat, early);
        check("wr0_low_lane", port_out[15:0], 16'h00FF);

        bus(1'b1, 8'd1, 16'h1234, 1'b0, 1'b0, rd, ack, err, lat, early);
        check("wr_in_ack", ack, 1'b1);
        check("wr_in_nochange", port_out, 64'h0000_0000_A55A_00FF);

        bus(1'b0, 8'd9, 16'h0, 1'b0, 1'b0, rd, ack, err, lat, early);
        check("unmapped_berr", err, 1'b1);
        check("unmapped_no_dtack", ack, 1'b0);
        check("unmapped_lat", lat, 1);
        check("unmapped_rdata", rd, 16'h0000);

        @(negedge clk);
        port_in[47:32] = 16'h0001;
        @(posedge clk);
        @(posedge clk);
        #1 check("sync_irq_2edges", irq, 1'b1);
        @(posedge clk);
        #1 check("sync_irq_3edges", irq, 1'b0);

        bus(1'b0, 8'd8, 16'h0, 1'b0, 1'b0, rd, ack, err, lat, early);
        check("status_read", rd, 16'h0004);
        bus(1'b1, 8'd8, 16'h0004, 1'b0, 1'b0, rd, ack, err, lat, early);
        check("status_clear_irq", irq, 1'b1);

        @(negedge clk);
        port_in[47:32] = 16'h0003;
        repeat (3) @(negedge clk);
        check("race_pre_irq", irq, 1'b0);
        // This change reaches the flag on the same edge the clear commits.
        @(negedge clk);
        port_in[47:32] = 16'h0002;
        bus(1'b1, 8'd8, 16'h0004, 1'b0, 1'b0, rd, ack, err, lat, early);
        check("race_set_wins_irq", irq, 1'b0);
        bus(1'b0, 8'd8, 16'h0, 1'b0, 1'b0, rd, ack, err, lat, early);
        check("race_status", rd, 16'h0004);
        bus(1'b1, 8'd8, 16'h0004, 1'b0, 1'b0, rd, ack, err, lat, early);
        check("race_final_clear", irq, 1'b1);

        for (int i = 0; i < NP; i++) begin
            out_m[i] = 16'h0000;
            in_m[i]  = 16'h0000;
        end
        out_m[0] = 16'h00FF;
        out_m[1] = 16'hA55A;
        in_m[2]  = 16'h0002;
        flags_m  = '0;

        for (int it = 0; it < 80; it++) begin
            if ($urandom_range(0, 3) == 0) begin
                p = $urandom_range(0, NP - 1);
                v = 16'($urandom);
                if (v == in_m[p]) v = v ^ 16'h0001;
                @(negedge clk);
                port_in[16*p +: 16] = v;
                in_m[p]    = v;
                flags_m[p] = 1'b1;
                repeat (3) @(negedge clk);
            end else begin
                wr = 1'($urandom_range(0, 1));
                a  = 8'($urandom_range(0, 11));
                wd = 16'($urandom);
                su = 1'($urandom_range(0, 1));
                sl = 1'($urandom_range(0, 1));
                bus(wr, a, wd, su, sl, rd, ack, err, lat, early);
                exp_map = (32'(a) <= 2 * NP);
                idx = int'(a) / 2;
                check("rnd_dtack", ack, exp_map);
                check("rnd_berr", err, !exp_map);
                check("rnd_lat", lat, 1);
                if (!wr) begin
                    if (32'(a) < 2 * NP) exp_rd = a[0] ? in_m[idx] : out_m[idx];
                    else if (32'(a) == 2 * NP) exp_rd = 16'(flags_m);
                    else exp_rd = 16'h0000;
                    check("rnd_early", early, 16'h0000);
                    check("rnd_read", rd, exp_rd);
                end else begin
                    mask = {{8{~su}}, {8{~sl}}};
                    if (32'(a) < 2 * NP && !a[0]) begin
                        out_m[idx] = (out_m[idx] & ~mask) | (wd & mask);
                    end else if (32'(a) == 2 * NP) begin
                        flags_m = flags_m & ~(wd[NP-1:0] & mask[NP-1:0]);
                    end
                end
                for (int i = 0; i < NP; i++) exp_po[16*i +: 16] = out_m[i];
                check("rnd_port_out", port_out, exp_po);
                check("rnd_irq", irq, (flags_m == '0));
            end
        end

        // Aborted cycle on the 3-wait-state instance.
        @(negedge clk);
        addr = 8'd0; write = 1'b1; uds = 1'b0; lds = 1'b0; d3_drv = 16'hBEEF; enable3 = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1 check("abort_no_ack_yet", dtack3, 1'b1);
        @(negedge clk);
        enable3 = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 check("abort_no_latch", port_out3, {4{16'h5A00}});
        check("abort_released", dtack3, 1'b0);

        @(negedge clk);
        d3_drv = 16'h1111; enable3 = 1'b1;
        wait_ack3(lat);
        check("ws3_lat", lat, 3);
        check("ws3_latch", port_out3[15:0], 16'h1111);

        // Asynchronous reset while u_dut3 sits in ACK with enable still high.
        #2 reset_n = 1'b0;
        #1;
        check("rst_ack_port_out3", port_out3, {4{16'h5A00}});
        check("rst_ack_dtack3", dtack3, 1'b1);
        check("rst_ack_berr3", berr3, 1'b1);
        check("rst_ack_irq3", irq3, 1'b1);
        check("rst_ack_port_out", port_out, 64'h0);
        @(negedge clk);
        reset_n = 1'b1;
        wait_ack3(lat);
        check("rst_restart_lat", lat, 3);
        check("rst_restart_latch", port_out3[15:0], 16'h1111);
        @(negedge clk);
        enable3 = 1'b0;
        write = 1'b0;
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
